matrix_mem_ctrl: RTL and testbench
==================================

MATRIX_MEM_CTRL -- requirements
Module: matrix_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, matrix row count (>=1).
REQ-002 The block SHALL have parameter COLS, default 2, matrix column count (>=1).
REQ-003 The block SHALL have parameter WIDTH, default 8, element bit width.
REQ-004 The block SHALL have parameter ADDR_W, default 2, address width; ROWS*COLS <= 2**ADDR_W.
REQ-005 The block SHALL have parameter IDX_W, default 1, burst index width; max(ROWS,COLS) <= 2**IDX_W.
REQ-006 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have ports wr_en input 1, wr_addr input ADDR_W, wr_data input WIDTH: single write port, address = row*COLS+col.
REQ-009 The block SHALL have ports rd_en input 1, rd_addr input ADDR_W, rd_data output WIDTH, rd_valid output 1: random-access read port.
REQ-010 The block SHALL have ports burst_start input 1, burst_mode input 1 (0=row, 1=column), burst_index input IDX_W: streaming-readout request.
REQ-011 The block SHALL have ports burst_data output WIDTH, burst_valid output 1, burst_last output 1: streaming-readout output.
REQ-012 The block SHALL have ports clear_start input 1, busy output 1 (high in CLEAR or BURST), addr_err output 1 (one-cycle error pulse).

Function
REQ-013 Storage SHALL be ROWS*COLS words of WIDTH bits; contents SHALL NOT be affected by reset.
REQ-014 Write: wr_en high with wr_addr < ROWS*COLS -> mem[wr_addr] updated at that edge; accepted in IDLE and BURST, ignored in CLEAR.
REQ-015 Read: rd_en high at edge N -> rd_data = mem[rd_addr], rd_valid = 1 after edge N (latency 1); rd_valid low otherwise; rd_data holds last value when rd_valid low.
REQ-016 Read-during-write to same address SHALL return old data (read-before-write), both on rd port and burst port.
REQ-017 Out-of-range wr_addr: write dropped, addr_err pulses next cycle; out-of-range rd_addr: rd_data = 0, rd_valid = 1, addr_err pulses.
REQ-018 FSM states SHALL be IDLE, CLEAR, BURST; reset state IDLE.
REQ-019 IDLE->CLEAR on clear_start; CLEAR writes 0 to address k at cycle k, k=0..ROWS*COLS-1, then ->IDLE; duration exactly ROWS*COLS cycles.
REQ-020 IDLE->BURST on burst_start with valid index (row: index<ROWS; column: index<COLS); mode and index captured at start edge.
REQ-021 Row burst SHALL read addresses index*COLS+k, k=0..COLS-1; column burst SHALL read k*COLS+index, k=0..ROWS-1; one element per cycle.
REQ-022 burst_valid SHALL assert one cycle after each element read, burst_data registered; burst_last high with final element only; BURST->IDLE in the cycle burst_last is driven.
REQ-023 Invalid burst_index at burst_start: no burst, state stays IDLE, addr_err pulses.
REQ-024 clear_start and burst_start same edge in IDLE: CLEAR wins, burst request discarded.
REQ-025 clear_start/burst_start while busy SHALL be ignored (no queuing, no error).
REQ-026 rd port SHALL operate independently of FSM state in all states, including CLEAR (returns pre-clear value of not-yet-cleared words).

Reset
REQ-027 On rst low (asynchronous): state IDLE, rd_data=0, rd_valid=0, burst_data=0, burst_valid=0, burst_last=0, busy=0, addr_err=0, clear/burst counters 0.
REQ-028 Reset mid-CLEAR or mid-BURST SHALL abort immediately; already-cleared words stay 0, remaining words keep contents; no further burst_valid.
REQ-029 Release of rst SHALL be synchronous to clk internally; first operation accepted on the first rising edge after release.

Verification (bench: ROWS=2, COLS=3, WIDTH=8, ADDR_W=3, IDX_W=2)
REQ-030 Clear then write 0x11..0x16 to addr 0..5, rd_en addr 4 -> rd_data=0x15, rd_valid one cycle later; busy high exactly 6 cycles during clear.
REQ-031 Row burst index 1 -> burst_data 0x14,0x15,0x16 on consecutive cycles, burst_last with 0x16, busy low next cycle.
REQ-032 Column burst index 2 -> burst_data 0x13,0x16, burst_last with 0x16; column burst index 3 -> no burst_valid, addr_err one pulse.
REQ-033 Write 0xAA to addr 0 and rd_en addr 0 same edge -> rd_data=0x11; read next cycle -> 0xAA; wr_addr 7 -> no write, addr_err pulse.
REQ-034 clear_start and burst_start same edge -> CLEAR runs, no burst_valid; assert rst low at clear cycle 3 -> outputs 0, addr 0..2 read 0, addr 3..5 read 0x14..0x16.

Source files
------------

// File: rtl/matrix_mem_ctrl.sv
// Matrix-organised word store with a random-access read port, a single write port,
// a sequential clear engine and row/column streaming readout.
module matrix_mem_ctrl #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              burst_start,
  input  logic              burst_mode,
  input  logic [IDX_W-1:0]  burst_index,
  output logic [WIDTH-1:0]  burst_data,
  output logic              burst_valid,
  output logic              burst_last,
  input  logic              clear_start,
  output logic              busy,
  output logic              addr_err,
  output logic [1:0]        dbg_state_o
);

  localparam int                N_WORDS  = ROWS * COLS;
  localparam logic [ADDR_W:0]   NUM_W    = (ADDR_W+1)'(N_WORDS);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, BURST = 2'd2} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  mem_q [N_WORDS];
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] baddr_q;
  logic [ADDR_W-1:0] bstep_q;
  logic [IDX_W-1:0]  bcnt_q;
  logic [IDX_W-1:0]  blast_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  burst_data_q;
  logic              rd_valid_q;
  logic              burst_valid_q;
  logic              burst_last_q;
  logic              busy_q;
  logic              addr_err_q;

  logic wr_in_range;
  logic rd_in_range;
  logic bidx_ok;
  logic addr_err_d;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < NUM_W);
    rd_in_range = ({1'b0, rd_addr} < NUM_W);
    bidx_ok     = burst_mode ? (int'(burst_index) < COLS) : (int'(burst_index) < ROWS);
    addr_err_d  = 1'b0;
    if (wr_en && (state_q != CLEAR) && !wr_in_range) addr_err_d = 1'b1;
    if (rd_en && !rd_in_range) addr_err_d = 1'b1;
    if ((state_q == IDLE) && burst_start && !clear_start && !bidx_ok) addr_err_d = 1'b1;
  end

  // Storage has no reset; clear sweeps take priority over the external write port.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en && wr_in_range) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      baddr_q       <= '0;
      bstep_q       <= '0;
      bcnt_q        <= '0;
      blast_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      burst_data_q  <= '0;
      burst_valid_q <= 1'b0;
      burst_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      addr_err_q    <= addr_err_d;
      rd_valid_q    <= rd_en;
      burst_valid_q <= 1'b0;
      burst_last_q  <= 1'b0;
      if (rd_en) begin
        rd_data_q <= rd_in_range ? mem_q[rd_addr] : '0;
      end
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end else if (burst_start && bidx_ok) begin
            state_q <= BURST;
            busy_q  <= 1'b1;
            bcnt_q  <= '0;
            // Column bursts walk down a column in strides of COLS.
            baddr_q <= burst_mode ? ADDR_W'(burst_index) : ADDR_W'(int'(burst_index) * COLS);
            bstep_q <= burst_mode ? ADDR_W'(COLS) : ADDR_W'(1);
            blast_q <= burst_mode ? IDX_W'(ROWS - 1) : IDX_W'(COLS - 1);
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end
        end
        BURST: begin
          burst_data_q  <= mem_q[baddr_q];
          burst_valid_q <= 1'b1;
          baddr_q       <= baddr_q + bstep_q;
          bcnt_q        <= bcnt_q + 1'b1;
          if (bcnt_q == blast_q) begin
            burst_last_q <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            bcnt_q       <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign burst_data  = burst_data_q;
  assign burst_valid = burst_valid_q;
  assign burst_last  = burst_last_q;
  assign busy        = busy_q;
  assign addr_err    = addr_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Bench for matrix_mem_ctrl (2x3 matrix): directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based behavioural model.
module tb_matrix_mem_ctrl;

  localparam int ROWS = 2, COLS = 3, WIDTH = 8, ADDR_W = 3, IDX_W = 2;
  localparam int NW = ROWS * COLS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_en = 0, rd_en = 0, burst_start = 0, burst_mode = 0, clear_start = 0;
  logic [ADDR_W-1:0] wr_addr = 0, rd_addr = 0;
  logic [WIDTH-1:0]  wr_data = 0;
  logic [IDX_W-1:0]  burst_index = 0;
  logic [WIDTH-1:0]  rd_data, burst_data;
  logic              rd_valid, burst_valid, burst_last, busy, addr_err;
  logic [1:0]        dbg_state;

  matrix_mem_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .burst_start(burst_start), .burst_mode(burst_mode), .burst_index(burst_index),
    .burst_data(burst_data), .burst_valid(burst_valid), .burst_last(burst_last),
    .clear_start(clear_start), .busy(busy), .addr_err(addr_err), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m [NW];
  logic [WIDTH-1:0] old_m [NW];
  int clr_pend[$];
  int bq[$];
  logic [WIDTH-1:0] e_rd_data = 0, e_bd = 0;
  logic e_rd_valid = 0, e_bv = 0, e_bl = 0, e_busy = 0, e_addr_err = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_pend.delete();
      bq.delete();
      e_rd_data = 0; e_bd = 0; e_rd_valid = 0; e_bv = 0; e_bl = 0; e_busy = 0; e_addr_err = 0;
    end else begin
      old_m = m;
      e_addr_err = 0; e_bv = 0; e_bl = 0;
      e_rd_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_addr) < NW) e_rd_data = old_m[rd_addr];
        else begin e_rd_data = 0; e_addr_err = 1; end
      end
      if (clr_pend.size() > 0) begin
        m[clr_pend.pop_front()] = '0;
      end else begin
        if (bq.size() > 0) begin
          e_bd = old_m[bq.pop_front()];
          e_bv = 1;
          e_bl = (bq.size() == 0);
        end else if (clear_start) begin
          for (int k = 0; k < NW; k++) clr_pend.push_back(k);
        end else if (burst_start) begin
          if (!burst_mode && int'(burst_index) < ROWS)
            for (int k = 0; k < COLS; k++) bq.push_back(int'(burst_index) * COLS + k);
          else if (burst_mode && int'(burst_index) < COLS)
            for (int k = 0; k < ROWS; k++) bq.push_back(k * COLS + int'(burst_index));
          else e_addr_err = 1;
        end
        if (wr_en) begin
          if (int'(wr_addr) < NW) m[wr_addr] = wr_data;
          else e_addr_err = 1;
        end
      end
      e_busy = (clr_pend.size() > 0) || (bq.size() > 0);
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) begin
    #2;
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("rd_data", rd_data, e_rd_data);
    chk("burst_valid", burst_valid, e_bv);
    chk("burst_data", burst_data, e_bd);
    chk("burst_last", burst_last, e_bl);
    chk("busy", busy, e_busy);
    chk("addr_err", addr_err, e_addr_err);
    if (e_bv && exp_q.size() > 0) chk("burst_literal", burst_data, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic idle_in();
    wr_en = 0; rd_en = 0; burst_start = 0; clear_start = 0;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = WIDTH'(d);
    cyc();
    wr_en = 0;
  endtask

  task automatic do_read_chk(input string nm, input int a, input int exp);
    rd_en = 1; rd_addr = ADDR_W'(a);
    cyc();
    rd_en = 0;
    chk(nm, rd_data, exp);
    chk({nm, "_valid"}, rd_valid, 1);
  endtask

  task automatic run_burst(input logic mode, input int idx, input int exp_n, input int exp_last);
    int n_valid;
    int seen_last;
    n_valid = 0; seen_last = 0;
    burst_mode = mode; burst_index = IDX_W'(idx); burst_start = 1;
    cyc();
    burst_start = 0;
    for (int i = 0; i < 8 && seen_last == 0; i++) begin
      cyc();
      if (burst_valid) n_valid++;
      if (burst_last) begin
        seen_last = 1;
        chk("burst_last_data", burst_data, exp_last);
      end
    end
    chk("burst_count", n_valid, exp_n);
    chk("burst_last_seen", seen_last, 1);
    cyc();
    chk("busy_after_burst", busy, 0);
  endtask

  task automatic wait_not_busy();
    idle_in();
    for (int i = 0; i < 20 && busy; i++) cyc();
    chk("wait_not_busy", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    #1 rst = 0;
    cyc(); cyc();
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", dbg_state, 0);
    chk("reset_burst_valid", burst_valid, 0);
    rst = 1;

    // clear: busy for exactly NW cycles
    clear_start = 1;
    cyc();
    clear_start = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      cyc();
    end
    chk("clear_busy_cycles", busy_cnt, 6);
    do_read_chk("cleared_word", 2, 8'h00);

    for (int a = 0; a < NW; a++) do_write(a, 8'h11 + a);
    do_read_chk("read_addr4", 4, 8'h15);
    cyc();
    chk("rd_valid_drops", rd_valid, 0);
    chk("rd_data_holds", rd_data, 8'h15);

    exp_q.push_back(8'h14); exp_q.push_back(8'h15); exp_q.push_back(8'h16);
    run_burst(1'b0, 1, 3, 8'h16);
    exp_q.push_back(8'h13); exp_q.push_back(8'h16);
    run_burst(1'b1, 2, 2, 8'h16);

    // invalid column index
    burst_mode = 1; burst_index = 2'd3; burst_start = 1;
    cyc();
    burst_start = 0;
    chk("bad_idx_err", addr_err, 1);
    chk("bad_idx_busy", busy, 0);
    cyc();
    chk("bad_idx_err_pulse", addr_err, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bad_idx_no_burst", burst_valid, 0);
    end

    // read-before-write and out-of-range write
    wr_en = 1; wr_addr = 0; wr_data = 8'hAA; rd_en = 1; rd_addr = 0;
    cyc();
    idle_in();
    chk("rbw_old", rd_data, 8'h11);
    do_read_chk("rbw_new", 0, 8'hAA);
    wr_en = 1; wr_addr = 3'd7; wr_data = 8'h5A;
    cyc();
    wr_en = 0;
    chk("wr_oor_err", addr_err, 1);
    do_read_chk("rd_oor", 7, 8'h00);
    chk("rd_oor_err", addr_err, 1);
    do_read_chk("wr_oor_nochange5", 5, 8'h16);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_addr     = ADDR_W'($urandom_range(0, 7));
      wr_data     = WIDTH'($urandom);
      rd_en       = ($urandom_range(0, 1) == 0);
      rd_addr     = ADDR_W'($urandom_range(0, 7));
      burst_start = ($urandom_range(0, 5) == 0);
      burst_mode  = 1'($urandom_range(0, 1));
      burst_index = IDX_W'($urandom_range(0, 3));
      clear_start = ($urandom_range(0, 40) == 0);
      if (i == 300) begin
        rst = 0;
        cyc();
        rst = 1;
      end
      cyc();
    end

    // simultaneous clear/burst, then reset mid-clear
    wait_not_busy();
    for (int a = 0; a < NW; a++) do_write(a, 8'h11 + a);
    clear_start = 1; burst_start = 1; burst_mode = 0; burst_index = 0;
    cyc();
    idle_in();
    chk("clear_wins_busy", busy, 1);
    chk("clear_wins_state", dbg_state, 1);
    cyc(); cyc(); cyc();
    chk("clear_no_burst", burst_valid, 0);
    rst = 0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_state", dbg_state, 0);
    cyc();
    rst = 1;
    do_read_chk("after_rst_a0", 0, 8'h00);
    do_read_chk("after_rst_a1", 1, 8'h00);
    do_read_chk("after_rst_a2", 2, 8'h00);
    do_read_chk("after_rst_a3", 3, 8'h14);
    do_read_chk("after_rst_a4", 4, 8'h15);
    do_read_chk("after_rst_a5", 5, 8'h16);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_burst_after_rst", burst_valid, 0);
    end

    chk("literal_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
